// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [6:0] {
        Load   = 7'h03,
        OpImm  = 7'h13,
        Auipc  = 7'h17,
        Store  = 7'h23,
        Op     = 7'h33,
        Lui    = 7'h37,
        Branch = 7'h63,
        Jalr   = 7'h67,
        Jal    = 7'h6f
    } Opcode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } Signals;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        pred;
    } FetchEntry;

    function automatic logic [31:0] j_imm(input logic [31:0] insn);
        return {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// rtl/fetch_stage_buffer.sv - synchronous FIFO of FetchEntry with partial flush
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  FetchEntry        push_data,
    input  logic             pop,
    input  logic             flush,
    input  logic [CNT_W-1:0] flush_keep,
    output FetchEntry        head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    FetchEntry        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;
    logic [CNT_W-1:0] after_pop;
    logic [CNT_W-1:0] kept;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        return PTR_W'((int'(p) + n) % DEPTH);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head      = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    assign do_push   = push && !flush && (!full || do_pop);
    assign after_pop = count - CNT_W'(do_pop);
    // Flush keeps the oldest flush_keep entries that survive this cycle's pop.
    assign kept      = (flush_keep < after_pop) ? flush_keep : after_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= ptr_add(rd_ptr, 1);
            end
            if (flush) begin
                wr_ptr <= ptr_add(rd_ptr, int'(do_pop) + int'(kept));
                count  <= kept;
            end else begin
                if (do_push) begin
                    wr_ptr <= ptr_add(wr_ptr, 1);
                end
                count <= after_pop + CNT_W'(do_push);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage; define FETCH_JAL_PREDICT_EN for JAL predecode
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output Signals      o_signals,
    output logic        o_pred_taken
);

    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic             buf_full;
    logic             buf_empty;
    FetchEntry        head;
    FetchEntry        push_entry;
    logic             req_fire;
    logic             resp_take;
    logic             resp_keep;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_target;
    logic [31:0]      out_pc;
    logic [31:0]      out_insn;
    logic             out_pred;

    // Credit covers both in-flight requests and buffered entries so a push always has room.
    assign imem_req_valid  = !rst && !redirect_valid &&
                             ((SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(DEPTH));
    assign imem_req_addr   = fetch_pc;
    assign redirect_target = redirect_pc & ~32'd3;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign resp_take       = imem_resp_valid && (inflight != '0);
    assign resp_keep       = resp_take && (drop_cnt == '0) && !redirect_valid;
    assign push            = resp_keep && (!buf_full || pop);
    assign pop             = !stall && !buf_empty && !redirect_valid;
    assign inflight_next   = inflight + CNT_W'(req_fire) - CNT_W'(resp_take);

`ifdef FETCH_JAL_PREDICT_EN
    logic        pred_hit;
    logic [31:0] pred_target;

    assign pred_hit    = resp_keep && (imem_resp_data[6:0] == Jal);
    assign pred_target = resp_pc + j_imm(imem_resp_data);
`endif

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = resp_pc;
        push_entry.insn = imem_resp_data;
`ifdef FETCH_JAL_PREDICT_EN
        push_entry.pred = pred_hit;
`else
        push_entry.pred = 1'b0;
`endif
    end

    fetch_buffer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .flush_keep ('0),
        .head       (head),
        .count      (count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            out_pc   <= '0;
            out_insn <= NOP_INSN;
            out_pred <= 1'b0;
        end else begin
            inflight <= inflight_next;
            // Every request still outstanding after a PC change returns stale data.
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= inflight_next;
            end
`ifdef FETCH_JAL_PREDICT_EN
            else if (pred_hit) begin
                fetch_pc <= pred_target;
                resp_pc  <= pred_target;
                drop_cnt <= inflight_next;
            end
`endif
            else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (resp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end

            if (redirect_valid) begin
                out_insn <= NOP_INSN;
                out_pred <= 1'b0;
            end else if (!stall) begin
                if (!buf_empty) begin
                    out_pc   <= head.pc;
                    out_insn <= head.insn;
                    out_pred <= head.pred;
                end else begin
                    out_insn <= NOP_INSN;
                    out_pred <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_signals      = '0;
        o_signals.pc   = out_pc;
        o_signals.insn = out_insn;
    end

    assign o_pred_taken = out_pred;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard testbench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    Signals      o_signals;
    logic        o_pred_taken;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .o_signals       (o_signals),
        .o_pred_taken    (o_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          lat = 1;
    int          hs_total = 0;
    logic        last_hs = 1'b0;
    logic [31:0] last_addr = '0;
    bit          jal_mem = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_mem && a == 32'h10) return 32'h0400_00EF;
        return 32'hA500_0000 | a;
    endfunction

    // In-order memory with fixed latency; handshakes seen at a negedge complete on the next posedge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
            last_hs = 1'b0;
            imem_resp_valid = 1'b0;
            imem_resp_data = '0;
        end else begin
            if (imem_resp_valid) void'(pend.pop_front());
            if (last_hs) pend.push_back('{addr: last_addr, due: cyc + lat - 1});
            last_hs = imem_req_valid && imem_req_ready;
            last_addr = imem_req_addr;
            if (last_hs) hs_total = hs_total + 1;
            imem_resp_valid = (pend.size() > 0) && (pend[0].due <= cyc);
            imem_resp_data = imem_resp_valid ? mem_word(pend[0].addr) : 32'h0;
        end
    end

    logic upd = 1'b0;
    always @(posedge clk) upd <= !rst && !stall && !redirect_valid;

    int        checks = 0;
    int        errors = 0;
    FetchEntry exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] insn, input logic pred);
        exp_q.push_back('{pc: pc, insn: insn, pred: pred});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d outputs still pending after %0d cycles, expected 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic stall_test();
        int  n = 0;
        int  hs0;
        bit  seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = upd && (o_signals.pc == 32'h8) && (o_signals.insn != NOP_INSN);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_wait: pc 8 not presented within 60 cycles");
        end
        stall = 1'b1;
        hs0 = hs_total;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_pc", o_signals.pc, 32'h8);
            chk("stall_hold_insn", o_signals.insn, 32'hA500_0008);
        end
        checks++;
        if (hs_total - hs0 > DEPTH) begin
            errors++;
            $display("FAIL stall_credit: %0d requests during stall, expected at most %0d", hs_total - hs0, DEPTH);
        end
        stall = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                FetchEntry e;
                @(negedge clk);
                if (!rst && upd && o_signals.insn != NOP_INSN && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_pc", o_signals.pc, e.pc);
                    chk("out_insn", o_signals.insn, e.insn);
                    chk("out_pred", 32'(o_pred_taken), 32'(e.pred));
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc", o_signals.pc, 32'h0);
        chk("rst_insn", o_signals.insn, NOP_INSN);
        chk("rst_pred", 32'(o_pred_taken), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Sequential stream at latency 1 with a 3-cycle stall on pc 8
        for (int i = 0; i < 8; i++) expect_out(32'(i * 4), 32'hA500_0000 + 32'(i * 4), 1'b0);
        stall_test();
        wait_drain("stream", 100);

        // Redirect to 0x100 with two requests outstanding at latency 3
        lat = 3;
        do_reset();
        chk("mid_rst_pc", o_signals.pc, 32'h0);
        chk("mid_rst_insn", o_signals.insn, NOP_INSN);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        expect_out(32'h100, 32'hA500_0100, 1'b0);
        expect_out(32'h104, 32'hA500_0104, 1'b0);
        expect_out(32'h108, 32'hA500_0108, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect_pc = 32'h100;
        redirect_valid = 1'b1;
        @(negedge clk);
        chk("redir_req_block", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_bubble", o_signals.insn, NOP_INSN);
        chk("redir_addr", imem_req_addr, 32'h100);
        wait_drain("redirect", 100);

        // Redirect with stall and a same-cycle response, unaligned target
        lat = 1;
        do_reset();
        expect_out(32'h0, 32'hA500_0000, 1'b0);
        expect_out(32'h4, 32'hA500_0004, 1'b0);
        expect_out(32'h200, 32'hA500_0200, 1'b0);
        expect_out(32'h204, 32'hA500_0204, 1'b0);
        expect_out(32'h208, 32'hA500_0208, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_redir_pc", o_signals.pc, 32'h4);
        redirect_pc = 32'h203;
        redirect_valid = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        chk("redir_stall_req_block", 32'(imem_req_valid), 32'd0);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("redir_stall_insn", o_signals.insn, NOP_INSN);
        chk("redir_stall_pred", 32'(o_pred_taken), 32'd0);
        chk("redir_align_addr", imem_req_addr, 32'h200);
        wait_drain("redirect_stall", 100);

`ifdef FETCH_JAL_PREDICT_EN
        // JAL at 0x10 jumps to 0x50; 0x14 and 0x18 must never appear
        jal_mem = 1'b1;
        do_reset();
        expect_out(32'h0, 32'hA500_0000, 1'b0);
        expect_out(32'h4, 32'hA500_0004, 1'b0);
        expect_out(32'h8, 32'hA500_0008, 1'b0);
        expect_out(32'hC, 32'hA500_000C, 1'b0);
        expect_out(32'h10, 32'h0400_00EF, 1'b1);
        expect_out(32'h50, 32'hA500_0050, 1'b0);
        expect_out(32'h54, 32'hA500_0054, 1'b0);
        expect_out(32'h58, 32'hA500_0058, 1'b0);
        wait_drain("jal_predict", 100);
        jal_mem = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
